// File: rtl/fpm_pkg.sv
// Shared binary16 constants, flag indices and the stage-1 register record
// for the multiplier normalize/round/pack stage.
package fpm_pkg;

  localparam int EXP_W  = 5;
  localparam int MANT_W = 10;
  localparam int BIAS   = 15;
  localparam int PROD_W = 22;
  localparam int FLAG_W = 3;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [14:0] INF_MAG = 15'h7C00;

  // out_flags = {overflow, underflow, inexact}
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  // exp is the 8-bit two's complement biased exponent after normalization
  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] mant;
    logic              guard;
    logic              sticky;
    logic              zero;
    logic              inf;
    logic              nan;
  } s1_t;

endpackage

// File: rtl/fpm_normalize_round_if.sv
// Valid/ready bus between the product adder, the normalize/round stage and
// its consumer. master = upstream/consumer side, slave = the stage itself.
interface fpm_normalize_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [6:0]  in_exp;
  logic [21:0] in_prod;
  logic        in_zero;
  logic        in_inf;
  logic        in_nan;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_prod, in_zero, in_inf, in_nan, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_prod, in_zero, in_inf, in_nan, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fpm_round_rne.sv
// Round-to-nearest-even on a 10-bit mantissa with guard/sticky; carry_o
// signals overflow into the next binade (mantissa wraps to zero).
module fpm_round_rne
  import fpm_pkg::*;
(
  input  logic [MANT_W-1:0] mant_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  output logic [MANT_W-1:0] mant_o,
  output logic              carry_o,
  output logic              inexact_o
);
  logic            inc;
  logic [MANT_W:0] sum;

  always_comb begin
    inc       = guard_i & (sticky_i | mant_i[0]);
    sum       = {1'b0, mant_i} + {{MANT_W{1'b0}}, inc};
    mant_o    = sum[MANT_W-1:0];
    carry_o   = sum[MANT_W];
    inexact_o = guard_i | sticky_i;
  end
endmodule

// File: rtl/fpm_normalize_round.sv
// Normalize/round/pack stage of the binary16 multiplier, 2-stage valid/ready.
// Define FPM_SUBNORMAL_EN for gradual underflow; otherwise tiny results flush to zero.
module fpm_normalize_round
  import fpm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fpm_normalize_round_if.slave io
);
  s1_t         s1_d, s1_q, s1_in;
  logic        s1_valid_d, s1_valid_q;
  logic        s2_valid_d, s2_valid_q;
  logic [15:0] out_result_d, out_result_q;
  logic [2:0]  out_flags_d, out_flags_q;

  logic        s2_load, s1_adv, in_ready_c;
  logic [15:0] res_c;
  logic [2:0]  flg_c;
  logic signed [8:0] exp_rnd;

  logic [MANT_W-1:0] rn_mant;
  logic              rn_carry, rn_inx;

  // ---------------- handshake ----------------
  always_comb begin
    s2_load    = !s2_valid_q || io.out_ready;
    s1_adv     = s1_valid_q && s2_load;
    in_ready_c = !s1_valid_q || s1_adv;
  end

  assign io.in_ready   = in_ready_c;
  assign io.out_valid  = s2_valid_q;
  assign io.out_result = out_result_q;
  assign io.out_flags  = out_flags_q;

  // ---------------- stage 1: normalize ----------------
  always_comb begin
    s1_in.sign = io.in_sign;
    s1_in.zero = io.in_zero;
    s1_in.inf  = io.in_inf;
    s1_in.nan  = io.in_nan;
    if (io.in_prod[21]) begin
      s1_in.mant   = io.in_prod[20:11];
      s1_in.guard  = io.in_prod[10];
      s1_in.sticky = |io.in_prod[9:0];
      s1_in.exp    = {io.in_exp[6], io.in_exp} + 8'd1;
    end else begin
      s1_in.mant   = io.in_prod[19:10];
      s1_in.guard  = io.in_prod[9];
      s1_in.sticky = |io.in_prod[8:0];
      s1_in.exp    = {io.in_exp[6], io.in_exp};
    end
  end

  always_comb begin
    s1_valid_d = in_ready_c ? io.in_valid : s1_valid_q;
    s1_d       = (io.in_valid && in_ready_c) ? s1_in : s1_q;
  end

  // ---------------- stage 2: round / pack ----------------
  fpm_round_rne u_rne_norm (
    .mant_i    (s1_q.mant),
    .guard_i   (s1_q.guard),
    .sticky_i  (s1_q.sticky),
    .mant_o    (rn_mant),
    .carry_o   (rn_carry),
    .inexact_o (rn_inx)
  );

`ifdef FPM_SUBNORMAL_EN
  // Denormalize by (1 - exp). The first position of the shift moves the guard
  // straight into sticky, so shift {1,mant} by the remaining (sh - 1).
  logic signed [8:0]  sh_full;
  logic [3:0]         sh_m1;
  logic [MANT_W:0]    sub_v, sub_sft;
  logic               sub_lost;
  logic [MANT_W-1:0]  sub_mant;
  logic               sub_carry, sub_inx;

  always_comb begin
    sh_full  = 9'sd1 - $signed({s1_q.exp[7], s1_q.exp});
    sh_m1    = (sh_full > 9'sd12) ? 4'd11 : 4'(sh_full[3:0] - 4'd1);
    sub_v    = {1'b1, s1_q.mant};
    sub_sft  = sub_v >> sh_m1;
    sub_lost = s1_q.guard | (|(sub_v & ~(11'h7FF << sh_m1)));
  end

  fpm_round_rne u_rne_sub (
    .mant_i    (sub_sft[MANT_W:1]),
    .guard_i   (sub_sft[0]),
    .sticky_i  (s1_q.sticky | sub_lost),
    .mant_o    (sub_mant),
    .carry_o   (sub_carry),
    .inexact_o (sub_inx)
  );
`endif

  always_comb begin
    res_c   = 16'h0000;
    flg_c   = '0;
    exp_rnd = $signed({s1_q.exp[7], s1_q.exp}) + $signed({8'd0, rn_carry});
    if (s1_q.nan) begin
      res_c = QNAN;
    end else if (s1_q.inf) begin
      res_c = {s1_q.sign, INF_MAG};
    end else if (s1_q.zero) begin
      res_c = {s1_q.sign, 15'h0000};
    end else if ($signed(s1_q.exp) <= 8'sd0) begin
`ifdef FPM_SUBNORMAL_EN
      // a carry here lands in the hidden bit: smallest normal, exponent field 1
      res_c          = {s1_q.sign, 4'd0, sub_carry, sub_mant};
      flg_c[FLG_UNF] = sub_inx & ~sub_carry;
      flg_c[FLG_INX] = sub_inx;
`else
      res_c          = {s1_q.sign, 15'h0000};
      flg_c[FLG_UNF] = 1'b1;
      flg_c[FLG_INX] = 1'b1;
`endif
    end else if (exp_rnd >= 9'sd31) begin
      res_c          = {s1_q.sign, INF_MAG};
      flg_c[FLG_OVF] = 1'b1;
      flg_c[FLG_INX] = 1'b1;
    end else begin
      res_c          = {s1_q.sign, exp_rnd[EXP_W-1:0], rn_mant};
      flg_c[FLG_INX] = rn_inx;
    end
  end

  always_comb begin
    s2_valid_d   = s2_load ? s1_valid_q : s2_valid_q;
    out_result_d = s1_adv ? res_c : out_result_q;
    out_flags_d  = s1_adv ? flg_c : out_flags_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s1_q         <= '0;
      out_result_q <= 16'h0000;
      out_flags_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      s1_q         <= s1_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end
endmodule
